sram_b_7abits_port_arbiter: RTL and testbench
=============================================

Name: sram_b_7abits_port_arbiter

Overview:
Shares one 128x8 1-write/1-read banked SRAM (CE0/A0/D0/WE0/WEM0 write port, CE1/A1/Q1 read port) between NWR write requesters and NRD read requesters. Each port has its own round-robin arbiter. The block removes same-cycle write/read address collisions, which the SRAM flags as a fatal simulation assertion. Read data returns with fixed 1-cycle latency, tagged with the requester id. It sits between accelerator PLM clients and the SRAM instance.

Parameters:
ABITS, 7, SRAM address width
DBITS, 8, SRAM data width; write mask has the same width
NWR, 2, number of write requesters (2..4)
NRD, 2, number of read requesters (2..4)
IDW, 1, requester id width, equal to clog2(max(NWR,NRD))

Ports:
CLK  in  1  clock
RST  in  1  asynchronous reset, active-high
wr_req  in  NWR  write request, one bit per requester
wr_addr  in  NWR*ABITS  write addresses, packed, requester i at slice i
wr_data  in  NWR*DBITS  write data, packed
wr_mask  in  NWR*DBITS  write bit-mask, packed
wr_gnt  out  NWR  one-hot write grant, combinational
rd_req  in  NRD  read request, one bit per requester
rd_addr  in  NRD*ABITS  read addresses, packed
rd_gnt  out  NRD  one-hot read grant, combinational
rd_valid  out  1  read data valid
rd_id  out  IDW  requester id for rd_data
rd_data  out  DBITS  read data, equal to Q1
CE0, A0, D0, WE0, WEM0  out  1/ABITS/DBITS/1/DBITS  SRAM write port
CE1, A1  out  1/ABITS  SRAM read port
Q1  in  DBITS  SRAM read data

Behaviour:
- Reset (asynchronous, immediate): wr_ptr=0, rd_ptr=0, rd_prio=0, rd_valid=0, rd_id=0. Grants and SRAM controls are combinational, so with no requests they are 0. An in-flight read is dropped: no rd_valid follows reset.
- Round-robin per port: the search starts at ptr and takes the first requester with req=1. On a grant, ptr becomes (winner+1) mod N. ptr is unchanged when there is no grant or the grant is suppressed.
- A request is a level. It stays asserted with stable addr/data/mask until its gnt is 1 in that cycle. A grant completes the transfer in that cycle.
- Write issue: CE0=WE0=1, A0/D0/WEM0 from the winner. Otherwise CE0=WE0=0, and A0/D0/WEM0=0.
- Read issue: CE1=1, A1 from the winner. Otherwise CE1=0, A1=0.
- Conflict: both candidates exist and have equal addresses.
  - If rd_prio=0: the write is granted and the read is suppressed (rd_gnt=0, CE1=0). Set rd_prio=1.
  - If rd_prio=1: the read is granted and the write is suppressed. Clear rd_prio.
  - Any granted read clears rd_prio.
  - Result: no read starves, and the SRAM never sees CE0&CE1&WE0 at the same address.
- No conflict: both ports are granted in the same cycle.
- Read latency: a read granted in cycle t gives rd_valid=1, rd_id=winner and rd_data=Q1 in cycle t+1.
  - Back-to-back reads give continuous rd_valid.
  - rd_data is undefined when rd_valid=0.
- A write followed by a read of the same address in the next cycle returns the new data (SRAM write-first across cycles). No forwarding logic.
- NWR=1 or NRD=1 degenerates to a pass-through with a constant id of 0.

Decomposition:
- Package sram_b_arb_pkg: default ABITS/DBITS, the clog2 function, and the id-width constant.
- Sub-module sram_b_rr_arb (params N, IDW): inputs req and a consume strobe; outputs one-hot gnt, a winner index, and a has_winner flag; holds its pointer internally. Instantiated once per port.
- The top level holds the conflict logic, rd_prio, and the rd_valid/rd_id pipeline register.

Test Plan:
1. Reset with all requests held high, then release RST → grants stay 0 during reset. The first cycle after release gives wr_gnt=01 and rd_gnt=01.
2. wr_req=11 held for 4 cycles with distinct addresses → wr_gnt sequence 01,10,01,10, and A0 alternates to match.
3. wr0 writes addr 5 with data 0xA5 and mask 0xFF; the next cycle rd1 reads addr 5 → rd_valid=1, rd_id=1, rd_data=0xA5 one cycle after rd_gnt.
4. wr0 and rd0 both target addr 0x12 every cycle → gnt alternates write, read, write. CE0&CE1 is never 1 at the same time; no SRAM assertion fires.
5. wr0 to addr 3 and rd0 to addr 4 in the same cycle → both granted. rd_valid follows in the next cycle.
6. Assert RST in the cycle after a read grant → rd_valid stays 0, and the pointers return to 0.

Source files
------------

// File: rtl/sram_b_arb_pkg.sv
// Shared defaults and width helpers for the SRAM port arbiter.
package sram_b_arb_pkg;
  localparam int DEF_ABITS = 7;
  localparam int DEF_DBITS = 8;
  localparam int DEF_NWR   = 2;
  localparam int DEF_NRD   = 2;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Id width never collapses to zero so single-requester builds still have a port.
  function automatic int id_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m < 2) ? 1 : clog2(m);
  endfunction

  localparam int ID_W = id_width(DEF_NWR, DEF_NRD);
endpackage

// File: rtl/sram_b_rr_arb.sv
// Round-robin arbiter: search starts at ptr, ptr advances past the winner on consume.
module sram_b_rr_arb #(
  parameter int N   = 2,
  parameter int IDW = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic           consume,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] winner,
  output logic           has_winner
);
  logic [IDW-1:0] ptr;

  always_comb begin : search
    int idx;
    idx        = 0;
    gnt        = '0;
    winner     = '0;
    has_winner = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!has_winner && req[idx]) begin
        has_winner = 1'b1;
        winner     = IDW'(idx);
        gnt[idx]   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ptr <= '0;
    else if (consume && has_winner)
      ptr <= (int'(winner) == N - 1) ? '0 : IDW'(winner + 1'b1);
  end
endmodule

// File: rtl/sram_b_7abits_port_arbiter.sv
// Shares a 1W/1R SRAM among several writers and readers, steering away from
// same-address write/read collisions and tagging read data with the requester id.
module sram_b_7abits_port_arbiter
  import sram_b_arb_pkg::*;
#(
  parameter int ABITS = DEF_ABITS,
  parameter int DBITS = DEF_DBITS,
  parameter int NWR   = DEF_NWR,
  parameter int NRD   = DEF_NRD,
  parameter int IDW   = id_width(NWR, NRD)
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [NWR-1:0]       wr_req,
  input  logic [NWR*ABITS-1:0] wr_addr,
  input  logic [NWR*DBITS-1:0] wr_data,
  input  logic [NWR*DBITS-1:0] wr_mask,
  output logic [NWR-1:0]       wr_gnt,
  input  logic [NRD-1:0]       rd_req,
  input  logic [NRD*ABITS-1:0] rd_addr,
  output logic [NRD-1:0]       rd_gnt,
  output logic                 rd_valid,
  output logic [IDW-1:0]       rd_id,
  output logic [DBITS-1:0]     rd_data,
  output logic                 CE0,
  output logic [ABITS-1:0]     A0,
  output logic [DBITS-1:0]     D0,
  output logic                 WE0,
  output logic [DBITS-1:0]     WEM0,
  output logic                 CE1,
  output logic [ABITS-1:0]     A1,
  input  logic [DBITS-1:0]     Q1
);
  logic [NWR-1:0]   wr_cand;
  logic [NRD-1:0]   rd_cand;
  logic [IDW-1:0]   wr_win, rd_win;
  logic             wr_has, rd_has;
  logic [ABITS-1:0] wa, ra;
  logic [DBITS-1:0] wd, wm;
  logic             conflict, wr_go, rd_go, rd_prio;

  sram_b_rr_arb #(.N(NWR), .IDW(IDW)) u_wr_arb (
    .clk(CLK), .rst(RST), .req(wr_req), .consume(wr_go),
    .gnt(wr_cand), .winner(wr_win), .has_winner(wr_has)
  );

  sram_b_rr_arb #(.N(NRD), .IDW(IDW)) u_rd_arb (
    .clk(CLK), .rst(RST), .req(rd_req), .consume(rd_go),
    .gnt(rd_cand), .winner(rd_win), .has_winner(rd_has)
  );

  always_comb begin
    wa = wr_addr[int'(wr_win)*ABITS +: ABITS];
    wd = wr_data[int'(wr_win)*DBITS +: DBITS];
    wm = wr_mask[int'(wr_win)*DBITS +: DBITS];
    ra = rd_addr[int'(rd_win)*ABITS +: ABITS];
  end

  // On a collision rd_prio picks the side; a suppressed read wins next time.
  assign conflict = wr_has && rd_has && (wa == ra);
  assign wr_go    = !RST && wr_has && !(conflict && rd_prio);
  assign rd_go    = !RST && rd_has && !(conflict && !rd_prio);

  assign wr_gnt = wr_go ? wr_cand : '0;
  assign rd_gnt = rd_go ? rd_cand : '0;
  assign CE0    = wr_go;
  assign WE0    = wr_go;
  assign A0     = wr_go ? wa : '0;
  assign D0     = wr_go ? wd : '0;
  assign WEM0   = wr_go ? wm : '0;
  assign CE1    = rd_go;
  assign A1     = rd_go ? ra : '0;
  assign rd_data = Q1;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rd_prio  <= 1'b0;
      rd_valid <= 1'b0;
      rd_id    <= '0;
    end else begin
      if (rd_go)
        rd_prio <= 1'b0;
      else if (conflict && !rd_prio)
        rd_prio <= 1'b1;
      rd_valid <= rd_go;
      if (rd_go)
        rd_id <= rd_win;
    end
  end
endmodule

// File: tb/tb_sram_b_7abits_port_arbiter.sv
// Directed bench for the SRAM port arbiter with a behavioural 128x8 SRAM model.
module tb_sram_b_7abits_port_arbiter;
  logic        CLK = 1'b0;
  logic        RST;
  logic [1:0]  wr_req, rd_req;
  logic [13:0] wr_addr, rd_addr;
  logic [15:0] wr_data, wr_mask;
  logic [1:0]  wr_gnt, rd_gnt;
  logic        rd_valid;
  logic [0:0]  rd_id;
  logic [7:0]  rd_data;
  logic        CE0, WE0, CE1;
  logic [6:0]  A0, A1;
  logic [7:0]  D0, WEM0, Q1;

  int tests = 0;
  int fails = 0;
  int collisions = 0;
  logic [7:0] mem [0:127];

  always #5 CLK = ~CLK;

  sram_b_7abits_port_arbiter dut (
    .CLK(CLK), .RST(RST),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_mask(wr_mask), .wr_gnt(wr_gnt),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
    .rd_valid(rd_valid), .rd_id(rd_id), .rd_data(rd_data),
    .CE0(CE0), .A0(A0), .D0(D0), .WE0(WE0), .WEM0(WEM0),
    .CE1(CE1), .A1(A1), .Q1(Q1)
  );

  // SRAM model: masked write, registered read, flags same-address collisions.
  always @(posedge CLK) begin
    if (CE0 && WE0 && CE1 && A0 == A1) collisions <= collisions + 1;
    if (CE0 && WE0) mem[A0] <= (mem[A0] & ~WEM0) | (D0 & WEM0);
    if (CE1) Q1 <= mem[A1];
  end

  task automatic idle();
    wr_req = 2'b00; rd_req = 2'b00;
    wr_addr = '0; rd_addr = '0; wr_data = '0; wr_mask = '0;
  endtask

  task automatic step();
    @(negedge CLK);
    #1;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    idle();
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    wr_req = 2'b11; rd_req = 2'b11;
    wr_addr = {7'h11, 7'h10}; rd_addr = {7'h21, 7'h20};
    wr_data = '0; wr_mask = '0;
    step();
    tests++;
    if (wr_gnt !== 2'b00 || rd_gnt !== 2'b00) begin
      fails++; $display("FAIL reset_gnt got wr=%b rd=%b exp 00/00", wr_gnt, rd_gnt);
    end
    tests++;
    if (rd_valid !== 1'b0 || CE0 !== 1'b0 || CE1 !== 1'b0) begin
      fails++; $display("FAIL reset_ctrl got vld=%b ce0=%b ce1=%b exp 0", rd_valid, CE0, CE1);
    end
    RST = 1'b0;
    #1;
    tests++;
    if (wr_gnt !== 2'b01 || rd_gnt !== 2'b01) begin
      fails++; $display("FAIL release_gnt got wr=%b rd=%b exp 01/01", wr_gnt, rd_gnt);
    end
    tests++;
    if (A0 !== 7'h10 || A1 !== 7'h20 || CE0 !== 1'b1 || CE1 !== 1'b1) begin
      fails++; $display("FAIL release_addr got A0=%h A1=%h exp 10/20", A0, A1);
    end
  endtask

  task automatic test_wr_rr();
    do_reset();
    wr_req = 2'b11; wr_addr = {7'h11, 7'h10}; wr_data = '0; wr_mask = '0;
    #1;
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (wr_gnt !== ((i % 2 == 0) ? 2'b01 : 2'b10) || A0 !== ((i % 2 == 0) ? 7'h10 : 7'h11)) begin
        fails++; $display("FAIL wr_rr[%0d] got gnt=%b A0=%h", i, wr_gnt, A0);
      end
      step();
    end
  endtask

  task automatic test_wr_then_rd();
    do_reset();
    wr_req = 2'b01; wr_addr = {7'h00, 7'h05}; wr_data = {8'h00, 8'hA5}; wr_mask = {8'h00, 8'hFF};
    #1;
    tests++;
    if (wr_gnt !== 2'b01 || WE0 !== 1'b1 || D0 !== 8'hA5 || WEM0 !== 8'hFF) begin
      fails++; $display("FAIL wr_issue got gnt=%b we=%b d=%h m=%h", wr_gnt, WE0, D0, WEM0);
    end
    step();
    idle();
    rd_req = 2'b10; rd_addr = {7'h05, 7'h00};
    #1;
    tests++;
    if (rd_gnt !== 2'b10 || A1 !== 7'h05 || CE0 !== 1'b0) begin
      fails++; $display("FAIL rd_issue got gnt=%b A1=%h ce0=%b", rd_gnt, A1, CE0);
    end
    step();
    idle();
    #1;
    tests++;
    if (rd_valid !== 1'b1 || rd_id !== 1'b1 || rd_data !== 8'hA5) begin
      fails++; $display("FAIL rd_return got vld=%b id=%b data=%h exp 1/1/a5", rd_valid, rd_id, rd_data);
    end
  endtask

  task automatic test_conflict();
    do_reset();
    wr_req = 2'b01; wr_addr = {7'h00, 7'h12}; wr_data = {8'h00, 8'h3C}; wr_mask = {8'h00, 8'h0F};
    rd_req = 2'b01; rd_addr = {7'h00, 7'h12};
    #1;
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (wr_gnt !== ((i % 2 == 0) ? 2'b01 : 2'b00) || rd_gnt !== ((i % 2 == 1) ? 2'b01 : 2'b00)) begin
        fails++; $display("FAIL conflict_gnt[%0d] got wr=%b rd=%b", i, wr_gnt, rd_gnt);
      end
      tests++;
      if ((CE0 & CE1) !== 1'b0 || rd_valid !== (i == 2)) begin
        fails++; $display("FAIL conflict_ctrl[%0d] got ce0&ce1=%b vld=%b", i, CE0 & CE1, rd_valid);
      end
      if (i == 2) begin
        tests++;
        if (rd_data !== 8'h0C) begin
          fails++; $display("FAIL conflict_data got %h exp 0c", rd_data);
        end
      end
      step();
    end
    idle();
    #1;
    tests++;
    if (rd_valid !== 1'b1 || rd_id !== 1'b0 || collisions !== 0) begin
      fails++; $display("FAIL conflict_end got vld=%b id=%b collisions=%0d", rd_valid, rd_id, collisions);
    end
  endtask

  task automatic test_parallel();
    do_reset();
    wr_req = 2'b01; wr_addr = {7'h00, 7'h03}; wr_data = {8'h00, 8'h77}; wr_mask = {8'h00, 8'hFF};
    rd_req = 2'b01; rd_addr = {7'h00, 7'h04};
    #1;
    tests++;
    if (wr_gnt !== 2'b01 || rd_gnt !== 2'b01 || CE0 !== 1'b1 || CE1 !== 1'b1) begin
      fails++; $display("FAIL parallel_gnt got wr=%b rd=%b", wr_gnt, rd_gnt);
    end
    step();
    idle();
    #1;
    tests++;
    if (rd_valid !== 1'b1 || rd_id !== 1'b0 || rd_data !== 8'h00) begin
      fails++; $display("FAIL parallel_ret got vld=%b id=%b data=%h exp 1/0/00", rd_valid, rd_id, rd_data);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    rd_req = 2'b11; rd_addr = {7'h04, 7'h03};
    #1;
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (rd_gnt !== ((i == 1) ? 2'b10 : 2'b01) || A1 !== ((i == 1) ? 7'h04 : 7'h03)) begin
        fails++; $display("FAIL b2b_gnt[%0d] got gnt=%b A1=%h", i, rd_gnt, A1);
      end
      if (i > 0) begin
        tests++;
        if (rd_valid !== 1'b1 || rd_id !== ((i == 2) ? 1'b1 : 1'b0) || rd_data !== ((i == 1) ? 8'h77 : 8'h00)) begin
          fails++; $display("FAIL b2b_ret[%0d] got vld=%b id=%b data=%h", i, rd_valid, rd_id, rd_data);
        end
      end
      step();
    end
    idle();
    #1;
    tests++;
    if (rd_valid !== 1'b1 || rd_id !== 1'b0 || rd_data !== 8'h77) begin
      fails++; $display("FAIL b2b_last got vld=%b id=%b data=%h exp 1/0/77", rd_valid, rd_id, rd_data);
    end
  endtask

  task automatic test_reset_inflight();
    do_reset();
    wr_req = 2'b01; wr_addr = {7'h22, 7'h20}; wr_data = '0; wr_mask = '0;
    rd_req = 2'b01; rd_addr = {7'h23, 7'h21};
    #1;
    tests++;
    if (wr_gnt !== 2'b01 || rd_gnt !== 2'b01) begin
      fails++; $display("FAIL inflight_gnt got wr=%b rd=%b exp 01/01", wr_gnt, rd_gnt);
    end
    @(negedge CLK);
    RST = 1'b1;
    wr_req = 2'b11; rd_req = 2'b11;
    #1;
    tests++;
    if (rd_valid !== 1'b0 || rd_gnt !== 2'b00 || CE0 !== 1'b0) begin
      fails++; $display("FAIL inflight_drop got vld=%b rd_gnt=%b ce0=%b", rd_valid, rd_gnt, CE0);
    end
    step();
    tests++;
    if (rd_valid !== 1'b0) begin
      fails++; $display("FAIL inflight_hold got vld=%b exp 0", rd_valid);
    end
    RST = 1'b0;
    #1;
    tests++;
    if (wr_gnt !== 2'b01 || rd_gnt !== 2'b01) begin
      fails++; $display("FAIL ptr_cleared got wr=%b rd=%b exp 01/01", wr_gnt, rd_gnt);
    end
    step();
    idle();
  endtask

  initial begin
    for (int a = 0; a < 128; a++) mem[a] = 8'h00;
    Q1 = 8'h00;
    idle();
    test_reset();
    test_wr_rr();
    test_wr_then_rd();
    test_conflict();
    test_parallel();
    test_back_to_back();
    test_reset_inflight();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
